// File: rtl/reg_alu_seq_ctrl_pkg.sv
// Shared encodings for the register-bank + ALU execute sequencer:
// op codes, ALU control constants, FSM states and the bundled control/instruction types.
package reg_alu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SRA = 3'b111
  } op_e;

  localparam logic [2:0] FN_CLASS_IDLE  = 3'b000;
  localparam logic [2:0] FN_CLASS_ARITH = 3'b011;
  localparam logic [2:0] FN_CLASS_LOGIC = 3'b100;
  localparam logic [2:0] FN_CLASS_SHIFT = 3'b101;

  localparam logic [1:0] LOGIC_AND = 2'b00;
  localparam logic [1:0] LOGIC_OR  = 2'b01;
  localparam logic [1:0] LOGIC_XOR = 2'b10;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } state_e;

  typedef struct packed {
    logic       add_sub;
    logic       const_var;
    logic [1:0] logic_fn;
    logic [1:0] shift_fn;
    logic [2:0] fn_class;
  } alu_ctrl_t;

  typedef struct packed {
    op_e        op;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
  } instr_t;

endpackage

// File: rtl/reg_alu_seq_ctrl_if.sv
// Instruction handshake bus between the instruction source (master) and the sequencer (slave).
interface reg_alu_seq_ctrl_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] op;
  logic [3:0] rd;
  logic [3:0] rs;
  logic [3:0] rt;

  modport master (
    output instr_valid, op, rd, rs, rt,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, op, rd, rs, rt,
    output instr_ready
  );
endinterface

// File: rtl/reg_alu_seq_ctrl_alu_op_decode.sv
// Pure combinational mapping from op code to ALU control fields; unused fields are held at 0.
module alu_op_decode
  import reg_alu_seq_ctrl_pkg::*;
(
  input  op_e       op,
  output alu_ctrl_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (op)
      OP_ADD: begin ctrl.fn_class = FN_CLASS_ARITH; ctrl.add_sub = 1'b0;      end
      OP_SUB: begin ctrl.fn_class = FN_CLASS_ARITH; ctrl.add_sub = 1'b1;      end
      OP_AND: begin ctrl.fn_class = FN_CLASS_LOGIC; ctrl.logic_fn = LOGIC_AND; end
      OP_OR:  begin ctrl.fn_class = FN_CLASS_LOGIC; ctrl.logic_fn = LOGIC_OR;  end
      OP_XOR: begin ctrl.fn_class = FN_CLASS_LOGIC; ctrl.logic_fn = LOGIC_XOR; end
      OP_SLL: begin ctrl.fn_class = FN_CLASS_SHIFT; ctrl.shift_fn = SHIFT_SLL; end
      OP_SRL: begin ctrl.fn_class = FN_CLASS_SHIFT; ctrl.shift_fn = SHIFT_SRL; end
      OP_SRA: begin ctrl.fn_class = FN_CLASS_SHIFT; ctrl.shift_fn = SHIFT_SRA; end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/reg_alu_seq_ctrl.sv
// Four-state sequencer (IDLE/DECODE/EXEC/WB) driving register-bank addresses and ALU
// controls for one latched instruction, then pulsing the write enable once.
module reg_alu_seq_ctrl
  import reg_alu_seq_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_alu_seq_ctrl_if.slave     instr_if,
  output logic [REG_ADDR_W-1:0] rs_addr,
  output logic [REG_ADDR_W-1:0] rt_addr,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  reg_we,
  output logic                  add_sub,
  output logic                  const_var,
  output logic [1:0]            logic_fn,
  output logic [1:0]            shift_fn,
  output logic [2:0]            fn_class,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  disp_sel,
  output logic [DATA_W/2-1:0]   disp_out,
  output logic                  done,
  output logic [CNT_W-1:0]      retire_cnt
);

  state_e              state_q, state_d;
  instr_t              instr_q, instr_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]    retire_cnt_q, retire_cnt_d;
  logic                instr_ready;
  alu_ctrl_t           dec_ctrl;
  alu_ctrl_t           ctrl;

  alu_op_decode u_alu_op_decode (
    .op   (instr_q.op),
    .ctrl (dec_ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      result_q     <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      result_q     <= result_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    result_d     = result_q;
    retire_cnt_d = retire_cnt_q;
    instr_ready  = 1'b0;
    reg_we       = 1'b0;
    done         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_if.instr_valid) begin
          state_d    = ST_DECODE;
          instr_d.op = op_e'(instr_if.op);
          instr_d.rd = instr_if.rd;
          instr_d.rs = instr_if.rs;
          instr_d.rt = instr_if.rt;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WB;
      ST_WB: begin
        reg_we       = 1'b1;
        done         = 1'b1;
        result_d     = alu_result;
        retire_cnt_d = retire_cnt_q + CNT_W'(1);
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Addresses come straight from the instruction latch, so they hold their last value in IDLE.
  always_comb begin
    ctrl = (state_q == ST_IDLE) ? alu_ctrl_t'('0) : dec_ctrl;
  end

  assign instr_if.instr_ready = instr_ready;
  assign rs_addr    = REG_ADDR_W'(instr_q.rs);
  assign rt_addr    = REG_ADDR_W'(instr_q.rt);
  assign rd_addr    = REG_ADDR_W'(instr_q.rd);
  assign add_sub    = ctrl.add_sub;
  assign const_var  = ctrl.const_var;
  assign logic_fn   = ctrl.logic_fn;
  assign shift_fn   = ctrl.shift_fn;
  assign fn_class   = ctrl.fn_class;
  assign disp_out   = disp_sel ? result_q[DATA_W-1:DATA_W/2] : result_q[DATA_W/2-1:0];
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_reg_alu_seq_ctrl.sv
// Directed-vector bench for reg_alu_seq_ctrl; a second instance with a 2-bit counter
// runs in lockstep so counter wrap is exercised within a short run.
module tb_reg_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [2:0]  op;
  logic [3:0]  rd, rs, rt;
  logic [31:0] alu_result;
  logic        disp_sel;

  always #5 clk = ~clk;

  reg_alu_seq_ctrl_if bus   ();
  reg_alu_seq_ctrl_if bus_w ();

  assign bus.instr_valid   = valid;
  assign bus.op            = op;
  assign bus.rd            = rd;
  assign bus.rs            = rs;
  assign bus.rt            = rt;
  assign bus_w.instr_valid = valid;
  assign bus_w.op          = op;
  assign bus_w.rd          = rd;
  assign bus_w.rs          = rs;
  assign bus_w.rt          = rt;

  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic        reg_we, add_sub, const_var, done;
  logic [1:0]  logic_fn, shift_fn;
  logic [2:0]  fn_class;
  logic [15:0] disp_out;
  logic [15:0] retire_cnt;

  logic [4:0]  w_rs_addr, w_rt_addr, w_rd_addr;
  logic        w_reg_we, w_add_sub, w_const_var, w_done;
  logic [1:0]  w_logic_fn, w_shift_fn;
  logic [2:0]  w_fn_class;
  logic [15:0] w_disp_out;
  logic [1:0]  w_retire_cnt;

  reg_alu_seq_ctrl #(.REG_ADDR_W(5), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .instr_if(bus.slave),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .reg_we(reg_we), .add_sub(add_sub), .const_var(const_var),
    .logic_fn(logic_fn), .shift_fn(shift_fn), .fn_class(fn_class),
    .alu_result(alu_result), .disp_sel(disp_sel), .disp_out(disp_out),
    .done(done), .retire_cnt(retire_cnt)
  );

  reg_alu_seq_ctrl #(.REG_ADDR_W(5), .DATA_W(32), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .instr_if(bus_w.slave),
    .rs_addr(w_rs_addr), .rt_addr(w_rt_addr), .rd_addr(w_rd_addr),
    .reg_we(w_reg_we), .add_sub(w_add_sub), .const_var(w_const_var),
    .logic_fn(w_logic_fn), .shift_fn(w_shift_fn), .fn_class(w_fn_class),
    .alu_result(alu_result), .disp_sel(disp_sel), .disp_out(w_disp_out),
    .done(w_done), .retire_cnt(w_retire_cnt)
  );

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  // {fn_class, logic_fn, shift_fn, add_sub} per op, hand-encoded
  logic [7:0] exp_ctrl [8] = '{8'h60, 8'h61, 8'h80, 8'h88, 8'h90, 8'hA0, 8'hA2, 8'hA4};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_busy(input logic [2:0] eop, input logic [3:0] erd, input logic [3:0] ers,
                            input logic [3:0] ert, input bit wb);
    check("busy_ready", 32'(bus.instr_ready), 32'd0);
    check("busy_ctrl", 32'({fn_class, logic_fn, shift_fn, add_sub}), 32'(exp_ctrl[eop]));
    check("busy_const_var", 32'(const_var), 32'd0);
    check("busy_rs_addr", 32'(rs_addr), 32'({1'b0, ers}));
    check("busy_rt_addr", 32'(rt_addr), 32'({1'b0, ert}));
    check("busy_rd_addr", 32'(rd_addr), 32'({1'b0, erd}));
    check("busy_reg_we", 32'(reg_we), 32'(wb));
    check("busy_done", 32'(done), 32'(wb));
    check("busy_w_reg_we", 32'(w_reg_we), 32'(wb));
  endtask

  task automatic check_idle(input logic [3:0] erd, input logic [3:0] ers, input logic [31:0] res);
    check("idle_ready", 32'(bus.instr_ready), 32'd1);
    check("idle_ctrl", 32'({fn_class, logic_fn, shift_fn, add_sub, const_var}), 32'd0);
    check("idle_reg_we", 32'({reg_we, done}), 32'd0);
    check("idle_rs_hold", 32'(rs_addr), 32'({1'b0, ers}));
    check("idle_rd_hold", 32'(rd_addr), 32'({1'b0, erd}));
    check("retire_cnt", 32'(retire_cnt), 32'(exp_cnt[15:0]));
    check("retire_cnt_w", 32'(w_retire_cnt), 32'(exp_cnt[1:0]));
    disp_sel = 1'b0;
    #1 check("disp_lo", 32'(disp_out), 32'(res[15:0]));
    disp_sel = 1'b1;
    #1 check("disp_hi", 32'(disp_out), 32'(res[31:16]));
    disp_sel = 1'b0;
  endtask

  // Called at a negedge in IDLE. mode 0: valid dropped after accept;
  // mode 1: valid held high; mode 2: valid high with new random fields every busy cycle.
  task automatic do_instr(input logic [2:0] iop, input logic [3:0] ird, input logic [3:0] irs,
                          input logic [3:0] irt, input logic [31:0] res, input int mode);
    check("accept_ready", 32'(bus.instr_ready), 32'd1);
    valid = 1'b1; op = iop; rd = ird; rs = irs; rt = irt;
    for (int ph = 0; ph < 3; ph++) begin
      @(negedge clk);
      if (mode == 0) valid = 1'b0;
      check_busy(iop, ird, irs, irt, ph == 2);
      if (ph == 1) alu_result = res;
      if (mode == 2) begin
        valid = 1'b1;
        op = 3'($urandom); rd = 4'($urandom); rs = 4'($urandom); rt = 4'($urandom);
      end
    end
    exp_cnt++;
    @(negedge clk);
    check_idle(ird, irs, res);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; op = '0; rd = '0; rs = '0; rt = '0;
    alu_result = '0; disp_sel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_ctrl", 32'({fn_class, logic_fn, shift_fn, add_sub, const_var}), 32'd0);
    check("rst_we_done", 32'({reg_we, done}), 32'd0);
    check("rst_addr", 32'({rs_addr, rt_addr, rd_addr}), 32'd0);
    check("rst_cnt", 32'(retire_cnt), 32'd0);
    check("rst_disp", 32'(disp_out), 32'd0);

    // Single add with a one-cycle valid pulse
    do_instr(3'b000, 4'd3, 4'd1, 4'd2, 32'h1234_5678, 0);

    // All eight ops back-to-back, valid held high
    for (int i = 0; i < 8; i++)
      do_instr(3'(i), 4'(i + 4), 4'(i + 1), 4'(15 - i), 32'hDEAD_BEEF, 1);
    valid = 1'b0;

    // Inputs scrambled and valid pulsed while busy: latched values must hold, no extra accept
    do_instr(3'b100, 4'd9, 4'd10, 4'd11, 32'hCAFE_F00D, 2);
    valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("no_extra_ready", 32'(bus.instr_ready), 32'd1);
      check("no_extra_we", 32'({reg_we, w_reg_we}), 32'd0);
      check("no_extra_cnt", 32'(retire_cnt), 32'(exp_cnt[15:0]));
    end

    // Reset asserted during EXEC drops the instruction
    valid = 1'b1; op = 3'b001; rd = 4'd7; rs = 4'd5; rt = 4'd6;
    @(negedge clk);
    valid = 1'b0;
    check_busy(3'b001, 4'd7, 4'd5, 4'd6, 1'b0);
    @(negedge clk);
    check("exec_fn_class", 32'(fn_class), 32'h3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    check("mid_rst_ready", 32'(bus.instr_ready), 32'd1);
    check("mid_rst_ctrl", 32'({fn_class, logic_fn, shift_fn, add_sub, const_var}), 32'd0);
    check("mid_rst_addr", 32'({rs_addr, rt_addr, rd_addr}), 32'd0);
    check("mid_rst_cnt", 32'({retire_cnt, 14'd0, w_retire_cnt}), 32'd0);
    check("mid_rst_disp", 32'(disp_out), 32'd0);
    repeat (4) begin
      check("mid_rst_no_we", 32'({reg_we, done, w_reg_we}), 32'd0);
      @(negedge clk);
    end

    // Normal operation resumes after the mid-instruction reset
    do_instr(3'b101, 4'd1, 4'd2, 4'd3, 32'h0000_00F0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
